// File: rtl/mem_arbiter_pkg.sv
// Shared types for the IF/LSU memory port arbiter.
package mem_arbiter_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ADDR = 2'd1,
    RESP = 2'd2,
    DONE = 2'd3
  } arb_state_e;

  typedef enum logic {
    OWN_IF  = 1'b0,
    OWN_LSU = 1'b1
  } arb_owner_e;

endpackage

// File: rtl/mem_arbiter.sv
// Shares one split-handshake memory port between instruction fetch and the LSU,
// one outstanding transaction at a time, LSU priority with an IF starvation guard.
module mem_arbiter
  import mem_arbiter_pkg::*;
#(
  parameter int AW         = 32,
  parameter int DW         = 32,
  parameter int STARVE_MAX = 4
) (
  input  logic            i_clk,
  input  logic            i_rst_n,
  input  logic            i_if_VALID,
  input  logic [AW-1:0]   i_if_addr,
  input  logic            i_if_kill,
  output logic            o_if_READY,
  output logic [DW-1:0]   o_if_rdata,
  input  logic            i_lsu_VALID,
  input  logic            i_lsu_we,
  input  logic [AW-1:0]   i_lsu_addr,
  input  logic [DW-1:0]   i_lsu_wdata,
  input  logic [DW/8-1:0] i_lsu_strb,
  output logic            o_lsu_READY,
  output logic [DW-1:0]   o_lsu_rdata,
  output logic            o_mem_VALID,
  output logic            o_mem_we,
  output logic [AW-1:0]   o_mem_addr,
  output logic [DW-1:0]   o_mem_wdata,
  output logic [DW/8-1:0] o_mem_strb,
  input  logic            i_mem_READY,
  input  logic            i_mem_rvalid,
  input  logic [DW-1:0]   i_mem_rdata,
  output logic            o_proto_err
);

  localparam int SW = DW / 8;
  localparam int CW = $clog2(STARVE_MAX + 1);
  localparam logic [CW-1:0] STARVE_LIMIT = CW'(STARVE_MAX);

  arb_state_e    state_reg, state_next;
  arb_owner_e    owner_reg, owner_next;
  logic          we_reg, we_next;
  logic [AW-1:0] addr_reg, addr_next;
  logic [DW-1:0] wdata_reg, wdata_next;
  logic [SW-1:0] strb_reg, strb_next;
  logic [CW-1:0] starve_reg, starve_next;
  logic          kill_reg, kill_next;
  logic [DW-1:0] if_rdata_reg, lsu_rdata_reg;
  logic          proto_err_reg;

  logic if_req, grant_lsu, grant_if;

  // A fetch being killed this cycle is not a contender.
  assign if_req    = i_if_VALID & ~i_if_kill;
  assign grant_lsu = i_lsu_VALID & ~(if_req & (starve_reg == STARVE_LIMIT));
  assign grant_if  = if_req & ~grant_lsu;

  always_comb begin
    state_next  = state_reg;
    owner_next  = owner_reg;
    we_next     = we_reg;
    addr_next   = addr_reg;
    wdata_next  = wdata_reg;
    strb_next   = strb_reg;
    starve_next = starve_reg;
    kill_next   = kill_reg;

    unique case (state_reg)
      IDLE: begin
        kill_next = 1'b0;
        if (grant_lsu) begin
          state_next = ADDR;
          owner_next = OWN_LSU;
          we_next    = i_lsu_we;
          addr_next  = i_lsu_addr;
          wdata_next = i_lsu_wdata;
          strb_next  = i_lsu_we ? i_lsu_strb : '0;
        end else if (grant_if) begin
          state_next = ADDR;
          owner_next = OWN_IF;
          we_next    = 1'b0;
          addr_next  = i_if_addr;
          strb_next  = '0;
        end

        if (grant_if || !i_if_VALID)
          starve_next = '0;
        else if (grant_lsu && starve_reg != STARVE_LIMIT)
          starve_next = starve_reg + CW'(1);
      end
      ADDR: begin
        if (i_mem_READY)
          state_next = RESP;
        if (owner_reg == OWN_IF && i_if_kill)
          kill_next = 1'b1;
      end
      RESP: begin
        if (i_mem_rvalid)
          state_next = DONE;
        if (owner_reg == OWN_IF && i_if_kill)
          kill_next = 1'b1;
      end
      DONE: begin
        state_next = IDLE;
        kill_next  = 1'b0;
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_reg  <= IDLE;
      owner_reg  <= OWN_IF;
      we_reg     <= 1'b0;
      addr_reg   <= '0;
      wdata_reg  <= '0;
      strb_reg   <= '0;
      starve_reg <= '0;
      kill_reg   <= 1'b0;
    end else begin
      state_reg  <= state_next;
      owner_reg  <= owner_next;
      we_reg     <= we_next;
      addr_reg   <= addr_next;
      wdata_reg  <= wdata_next;
      strb_reg   <= strb_next;
      starve_reg <= starve_next;
      kill_reg   <= kill_next;
    end
  end

  // Response capture; a kill arriving with the response also blocks the update.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      if_rdata_reg  <= '0;
      lsu_rdata_reg <= '0;
      proto_err_reg <= 1'b0;
    end else begin
      if (state_reg == RESP && i_mem_rvalid) begin
        if (owner_reg == OWN_LSU && !we_reg)
          lsu_rdata_reg <= i_mem_rdata;
        if (owner_reg == OWN_IF && !kill_reg && !i_if_kill)
          if_rdata_reg <= i_mem_rdata;
      end
      if (i_mem_rvalid && state_reg != RESP)
        proto_err_reg <= 1'b1;
    end
  end

  assign o_mem_VALID = (state_reg == ADDR);
  assign o_mem_we    = we_reg;
  assign o_mem_addr  = addr_reg;
  assign o_mem_wdata = wdata_reg;
  assign o_mem_strb  = strb_reg;

  assign o_lsu_READY = (state_reg == DONE) && (owner_reg == OWN_LSU);
  assign o_if_READY  = (state_reg == DONE) && (owner_reg == OWN_IF) && !kill_reg;
  assign o_lsu_rdata = lsu_rdata_reg;
  assign o_if_rdata  = if_rdata_reg;
  assign o_proto_err = proto_err_reg;

endmodule
